// File: rtl/spi_cmd_decoder_pkg.sv
// ============================================================================
// Module   : spi_cmd_decoder_pkg
// Brief    : Shared types and constants for the SPI command decoder: FSM
//            state encoding, register addresses, command byte fields.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_cmd_decoder_pkg;

  // Decoder FSM states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  // Register widths
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DIGIT_W = 5;
  localparam int unsigned LED_W   = 4;

  // Fixed register addresses above the digit range
  localparam logic [ADDR_W-1:0] ADDR_LED    = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd7;

  // Command byte fields: {wr, reserved[3:0], start_addr[2:0]}
  localparam int unsigned CMD_WR_BIT  = 7;
  localparam int unsigned CMD_RSVD_HI = 6;
  localparam int unsigned CMD_RSVD_LO = 3;
  localparam int unsigned CMD_ADDR_HI = 2;

  // Digit code the display renders as blank
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'd20;

  // A command is malformed when any reserved bit is set
  function automatic logic cmd_is_bad(input logic [7:0] cmd);
    return |cmd[CMD_RSVD_HI:CMD_RSVD_LO];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ============================================================================
// Module   : spi_reg_bank
// Brief    : Digit / LED / status registers behind the SPI command decoder.
//            One write port, one combinational read port, sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bank #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter logic [4:0]  BLANK_CODE = spi_cmd_decoder_pkg::BLANK_CODE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [2:0]                  waddr,
  input  logic [7:0]                  wdata,
  input  logic                        err_set,
  input  logic [2:0]                  raddr,
  output logic [7:0]                  rdata,
  output logic [NUM_DIGITS-1:0][4:0]  digits,
  output logic [3:0]                  led,
  output logic                        err
);
  import spi_cmd_decoder_pkg::*;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q, digits_d;
  logic [LED_W-1:0]                   led_q, led_d;
  logic                               err_q, err_d;

  // Upper data bits have no home in any register
  logic unused_wdata;
  assign unused_wdata = ^wdata[7:5];

  // Next-state of every register; a new error outranks a clear in the same cycle
  always_comb begin
    digits_d = digits_q;
    led_d    = led_q;
    err_d    = err_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (we && (waddr == 3'(i))) begin
        digits_d[i] = wdata[DIGIT_W-1:0];
      end
    end
    if (we && (waddr == ADDR_LED)) begin
      led_d = wdata[LED_W-1:0];
    end
    if (we && (waddr == ADDR_STATUS) && wdata[0]) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  // Register state, asynchronously returned to the blank display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        digits_q[i] <= BLANK_CODE;
      end
      led_q <= '0;
      err_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      led_q    <= led_d;
      err_q    <= err_d;
    end
  end

  // Combinational read port, narrower registers zero-extended
  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (raddr == 3'(i)) begin
        rdata = {3'b000, digits_q[i]};
      end
    end
    if (raddr == ADDR_LED) begin
      rdata = {4'b0000, led_q};
    end
    if (raddr == ADDR_STATUS) begin
      rdata = {7'b0000000, err_q};
    end
  end

  assign digits = digits_q;
  assign led    = led_q;
  assign err    = err_q;

endmodule

`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
// ============================================================================
// Module   : spi_cmd_decoder
// Brief    : Parses SPI byte frames into register read/write commands and
//            drives the display digits, LEDs and the next SPI transmit byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_decoder #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter logic [4:0]  BLANK_CODE = spi_cmd_decoder_pkg::BLANK_CODE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic [4:0] digit4,
  output logic [4:0] digit5,
  output logic [3:0] led,
  output logic       err
);
  import spi_cmd_decoder_pkg::*;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  // Set by reset: a reset may land mid-frame, so bytes are not trusted
  // as commands until ss has been seen high once.
  logic               reset_sync_q, reset_sync_d;

  logic               bank_we;
  logic               bank_err_set;
  logic [7:0]         bank_rdata;
  logic [NUM_DIGITS-1:0][4:0] bank_digits;

  spi_reg_bank #(
    .NUM_DIGITS (NUM_DIGITS),
    .BLANK_CODE (BLANK_CODE)
  ) u_reg_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we),
    .waddr   (ptr_q),
    .wdata   (rx_data),
    .err_set (bank_err_set),
    .raddr   (ptr_d),
    .rdata   (bank_rdata),
    .digits  (bank_digits),
    .led     (led),
    .err     (err)
  );

  // Frame parser: the received byte is consumed first, then ss high forces IDLE
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    reset_sync_d = reset_sync_q & ~ss;
    bank_we      = 1'b0;
    bank_err_set = 1'b0;
    if (reset_sync_q && !ss) begin
      state_d = ST_DISCARD;
    end else begin
      if (rx_valid) begin
        unique case (state_q)
          ST_IDLE: begin
            if (cmd_is_bad(rx_data)) begin
              bank_err_set = 1'b1;
              state_d      = ST_DISCARD;
            end else begin
              ptr_d   = rx_data[CMD_ADDR_HI:0];
              state_d = rx_data[CMD_WR_BIT] ? ST_WRITE : ST_READ;
            end
          end
          ST_WRITE: begin
            bank_we = 1'b1;
            ptr_d   = ptr_q + 3'd1;
          end
          ST_READ: begin
            ptr_d = ptr_q + 3'd1;
          end
          default: begin
          end
        endcase
      end
      if (ss) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Transmit byte tracks reg[ptr] one cycle behind any pointer update
  always_comb begin
    tx_data_d = (state_d == ST_READ) ? bank_rdata : 8'h00;
  end

  // FSM, pointer and transmit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      tx_data_q    <= 8'h00;
      reset_sync_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tx_data_q    <= tx_data_d;
      reset_sync_q <= reset_sync_d;
    end
  end

  assign tx_data = tx_data_q;
  assign digit0  = bank_digits[0];
  assign digit1  = bank_digits[1];
  assign digit2  = bank_digits[2];
  assign digit3  = bank_digits[3];
  assign digit4  = bank_digits[4];
  assign digit5  = bank_digits[5];

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
// ============================================================================
// Module   : tb_spi_cmd_decoder
// Brief    : Self-checking bench for spi_cmd_decoder. Every received byte
//            pushes the tx_data expected one cycle later onto a scoreboard;
//            a monitor pops and compares. Register outputs are checked
//            directly after each frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_decoder;

  logic       clk;
  logic       rst_n;
  logic       ss;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic [4:0] digit0, digit1, digit2, digit3, digit4, digit5;
  logic [3:0] led;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  logic     rx_seen;

  spi_cmd_decoder #(
    .NUM_DIGITS (6),
    .BLANK_CODE (5'd20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss       (ss),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_data  (tx_data),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .digit4   (digit4),
    .digit5   (digit5),
    .led      (led),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Remember which edges carried a byte
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_seen <= 1'b0;
    else        rx_seen <= rx_valid;
  end

  // One cycle after each byte, tx_data must match the scoreboard head
  always @(negedge clk) begin : mon
    sb_item_t it;
    if (rx_seen) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        it = sb_q.pop_front();
        check_eq(it.tag, 32'(tx_data), 32'(it.exp));
      end
    end
  end

  // Drive one byte for one cycle (called on a falling edge) and queue its tx expectation
  task automatic send(input logic [7:0] b, input logic [7:0] exp_tx, input string tag);
    rx_valid = 1'b1;
    rx_data  = b;
    sb_q.push_back('{tag: tag, exp: exp_tx});
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Hold ss high for one cycle to close a frame, then lower it again
  task automatic end_frame();
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    rst_n    = 1'b0;
    ss       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_digit0", 32'(digit0), 32'd20);
    check_eq("rst_digit5", 32'(digit5), 32'd20);
    check_eq("rst_led",    32'(led),    32'd0);
    check_eq("rst_err",    32'(err),    32'd0);
    check_eq("rst_tx",     32'(tx_data), 32'd0);

    // Write digits 0..2
    ss = 1'b0;
    send(8'h80, 8'h00, "fa_cmd");
    send(8'h01, 8'h00, "fa_d0");
    check_eq("wr_latency_digit0", 32'(digit0), 32'd1);
    send(8'h02, 8'h00, "fa_d1");
    send(8'h03, 8'h00, "fa_d2");
    end_frame();
    check_eq("fa_digit0", 32'(digit0), 32'd1);
    check_eq("fa_digit1", 32'(digit1), 32'd2);
    check_eq("fa_digit2", 32'(digit2), 32'd3);
    check_eq("fa_digit3", 32'(digit3), 32'd20);
    check_eq("fa_digit4", 32'(digit4), 32'd20);

    // LED, ignored status write, pointer wrap to digit0 (back-to-back bytes)
    send(8'h86, 8'h00, "fb_cmd");
    send(8'h0F, 8'h00, "fb_led");
    send(8'hAA, 8'h00, "fb_status");
    send(8'h05, 8'h00, "fb_wrap");
    end_frame();
    check_eq("fb_led",    32'(led),    32'hF);
    check_eq("fb_err",    32'(err),    32'd0);
    check_eq("fb_digit0", 32'(digit0), 32'd5);

    // digit5 = 9
    send(8'h85, 8'h00, "fc_cmd");
    send(8'h09, 8'h00, "fc_d5");
    end_frame();
    check_eq("fc_digit5", 32'(digit5), 32'd9);

    // Read from 5 with wrap: 9, led F, status 0, digit0 5
    send(8'h05, 8'h09, "rd_digit5");
    send(8'h00, 8'h0F, "rd_led");
    send(8'h00, 8'h00, "rd_status");
    send(8'h00, 8'h05, "rd_wrap_digit0");
    end_frame();
    check_eq("rd_tx_after_frame", 32'(tx_data), 32'd0);

    // Bad command sets err, data byte discarded
    send(8'h48, 8'h00, "bad_cmd");
    send(8'h11, 8'h00, "bad_data");
    end_frame();
    check_eq("bad_err",    32'(err),    32'd1);
    check_eq("bad_digit0", 32'(digit0), 32'd5);
    check_eq("bad_digit1", 32'(digit1), 32'd2);
    send(8'h07, 8'h01, "rd_status_set");
    end_frame();

    // Clear err through the status register
    send(8'h87, 8'h00, "clr_cmd");
    send(8'h01, 8'h00, "clr_data");
    end_frame();
    check_eq("clr_err", 32'(err), 32'd0);
    send(8'h07, 8'h00, "rd_status_clr");
    end_frame();

    // Byte with ss high is processed, then IDLE; byte arriving with ss high is a command
    send(8'h81, 8'h00, "sshi_cmd");
    ss = 1'b1;
    send(8'h07, 8'h00, "sshi_last");
    send(8'h03, 8'h00, "sshi_cmd_ss_high");
    ss = 1'b0;
    send(8'h03, 8'h14, "sshi_read_digit3");
    end_frame();
    check_eq("sshi_digit1", 32'(digit1), 32'd7);
    check_eq("sshi_digit2", 32'(digit2), 32'd3);

    // Reset mid-write-frame with ss held low
    send(8'h80, 8'h00, "mr_cmd");
    send(8'h07, 8'h00, "mr_d0");
    check_eq("mr_pre_digit0", 32'(digit0), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_async_digit0", 32'(digit0), 32'd20);
    check_eq("mr_async_led",    32'(led),    32'd0);
    check_eq("mr_async_digit1", 32'(digit1), 32'd20);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h81, 8'h00, "mr_ignored_a");
    send(8'h09, 8'h00, "mr_ignored_b");
    check_eq("mr_digit1_kept", 32'(digit1), 32'd20);
    check_eq("mr_err_kept",    32'(err),    32'd0);
    end_frame();
    send(8'h82, 8'h00, "mr_next_cmd");
    send(8'h0C, 8'h00, "mr_next_d2");
    end_frame();
    check_eq("mr_next_digit2", 32'(digit2), 32'd12);
    check_eq("mr_next_digit1", 32'(digit1), 32'd20);

    // Let the monitor drain the scoreboard
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command decoder that sits directly downstream of the SPI slave byte interface and upstream of the seven-segment driver and board LEDs. Received bytes are parsed into framed register read/write commands against a small register bank. The bank's outputs drive the six display digits and four LEDs. It also supplies the byte the SPI slave shifts out on the next transfer.

## Interface
- `NUM_DIGITS`, 6: number of 5-bit digit registers, at addresses 0..NUM_DIGITS-1.
- `BLANK_CODE`, 20: digit reset value; the display renders it blank.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `ss`  in  1  SPI select, already synchronised to `clk`, active-low; high ends a frame.
- `rx_valid`  in  1  one-cycle pulse: `rx_data` holds a complete received byte.
- `rx_data`  in  8  received byte.
- `tx_data`  out  8  byte for the SPI slave to load for the next transfer.
- `digit0`..`digit5`  out  5 each  display digit codes.
- `led`  out  4  LED register.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Frame: `ss` low. The first byte is the command, and the following bytes are data.
- Command byte layout:
  - bit7 = 1 is a write; bit7 = 0 is a read.
  - bits[6:3] must be 0.
  - bits[2:0] give the start address.
- Register map:
  - 0..5: digits. Only the low 5 bits are stored; reads zero-extend.
  - 6: `led`. Only the low 4 bits are stored.
  - 7: status, read as {7'b0, err}. Writing bit0 = 1 clears `err`; other written values have no effect.
- States: IDLE, WRITE, READ, DISCARD.
- IDLE:
  - On `rx_valid` with a bad command (bits[6:3] ≠ 0): set `err` and go to DISCARD.
  - Otherwise: load the address pointer from bits[2:0] and go to WRITE or READ.
- WRITE: each `rx_valid` writes `rx_data` to reg[ptr], then `ptr` increments.
- READ: each `rx_valid` increments `ptr`. The byte content is ignored.
- DISCARD: ignore all bytes until the frame ends.
- `ptr` is 3 bits and wraps 7→0 in both WRITE and READ.
- `ss` high returns the block to IDLE from any state, in the same cycle it is sampled.
- `ss` high while `rx_valid` is asserted: the byte is processed first, then the block goes to IDLE.
- `rx_valid` while `ss` is high: the byte is treated as a command (frame start is implied by the byte arriving).
- `tx_data`:
  - In READ: reg[ptr], registered, reflecting the current `ptr`.
  - In every other state: 0x00.

## Timing
- Reset values:
  - all digits = BLANK_CODE
  - `led` = 0
  - `err` = 0
  - `tx_data` = 0x00
  - state = IDLE
  - `ptr` = 0
- A write becomes visible on `digitN`/`led` one cycle after its `rx_valid` edge.
- `tx_data` is valid one cycle after the `rx_valid` that loaded or advanced `ptr`. This gives the SPI slave at least 7 SCK periods of margin.
- Read of a register written in the same cycle returns the new value on the following cycle.
- Status clear and a new bad command in the same cycle: set wins, so `err` = 1.
- Reset asserted mid-frame: everything returns to reset values immediately. The remainder of that frame is parsed as new commands only after `ss` toggles high; until then the block sits in DISCARD. A reset-sync bit records that a reset happened mid-frame.
- No backpressure. `rx_valid` may arrive on back-to-back cycles and every pulse must be consumed.

## Structure
- Shared package contents:
  - state encoding
  - address constants (ADDR_LED = 6, ADDR_STATUS = 7)
  - command field positions
  - BLANK_CODE
- Sub-module `spi_reg_bank`: holds the digit/led/status registers, with a write port (we, addr, wdata), a combinational read port, and the `err` set/clear logic.
- The FSM and pointer logic stay in the top.

## Test plan
- Reset, then idle: digits all 20, `led` = 0, `err` = 0, `tx_data` = 0x00.
- Frame {0x80, 0x01, 0x02, 0x03}, then `ss` high: digit0 = 1, digit1 = 2, digit2 = 3; other digits remain 20.
- Frame {0x86, 0x0F, 0xAA, 0x05}: `led` = 0xF; reg7 write 0xAA has no effect (`err` stays 0); `ptr` wraps, so digit0 = 5.
- Frame {0x05, x, x} after digit5 = 9: `tx_data` is 0x09, then 0x0F (led), then 0x00 (status), one cycle after each `rx_valid`.
- Frame {0x48, 0x11}: `err` = 1, nothing written. Then frame {0x87, 0x01}: `err` = 0.
- `rst_n` pulsed mid-write-frame with `ss` held low: registers reset, following bytes are ignored until `ss` rises, and the next frame works normally.
